// File: rtl/axi4_lite_pkg.sv
// rtl/axi4_lite_pkg.sv - shared AXI4-Lite response codes, widths and bridge FSM states
package axi4_lite_pkg;

  localparam int AXI_ADDR_WIDTH = 8;
  localparam int AXI_DATA_WIDTH = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_DATA,
    ST_RSP
  } bridge_state_e;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi4_lite_valid_hold.sv
// rtl/axi4_lite_valid_hold.sv - VALID/payload holding register: set on load, cleared on handshake
module axi4_lite_valid_hold #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] payload_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] payload_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] payload_q, payload_d;

  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    if (load_i) begin
      valid_d   = 1'b1;
      payload_d = payload_i;
    end else if (valid_q && ready_i) begin
      valid_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
    end
  end

  assign valid_o   = valid_q;
  assign payload_o = payload_q;

endmodule

// File: rtl/axi4_lite_master_bridge.sv
// rtl/axi4_lite_master_bridge.sv - single-outstanding command/response to AXI4-Lite master bridge
module axi4_lite_master_bridge
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_WIDTH    = AXI_ADDR_WIDTH,
  parameter int DATA_WIDTH    = AXI_DATA_WIDTH,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [ADDR_WIDTH-1:0]    cmd_addr,
  input  logic [DATA_WIDTH-1:0]    cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]  cmd_wstrb,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic [1:0]               rsp_resp,
  output logic                     rsp_write,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic [ADDR_WIDTH-1:0]    AWADDR,
  output logic                     AWVALID,
  input  logic                     AWREADY,
  output logic [DATA_WIDTH-1:0]    WDATA,
  output logic [DATA_WIDTH/8-1:0]  WSTRB,
  output logic                     WVALID,
  input  logic                     WREADY,
  input  logic [1:0]               BRESP,
  input  logic                     BVALID,
  output logic                     BREADY,
  output logic [ADDR_WIDTH-1:0]    ARADDR,
  output logic                     ARVALID,
  input  logic                     ARREADY,
  input  logic [DATA_WIDTH-1:0]    RDATA,
  input  logic [1:0]               RRESP,
  input  logic                     RVALID,
  output logic                     RREADY
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  bridge_state_e state_q, state_d;

  logic load_wr, load_rd, cap_b, cap_r;

  logic [DATA_WIDTH-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic [1:0]               rsp_resp_q, rsp_resp_d;
  logic                     rsp_write_q, rsp_write_d;
  logic [ERR_CNT_WIDTH-1:0] err_count_q, err_count_d;
  logic [1:0]               cap_resp;

  axi4_lite_valid_hold #(.WIDTH(ADDR_WIDTH)) u_aw_hold (
    .clk_i     (ACLK),
    .rst_ni    (ARESETN),
    .load_i    (load_wr),
    .payload_i (cmd_addr),
    .ready_i   (AWREADY),
    .valid_o   (AWVALID),
    .payload_o (AWADDR)
  );

  axi4_lite_valid_hold #(.WIDTH(DATA_WIDTH + STRB_WIDTH)) u_w_hold (
    .clk_i     (ACLK),
    .rst_ni    (ARESETN),
    .load_i    (load_wr),
    .payload_i ({cmd_wstrb, cmd_wdata}),
    .ready_i   (WREADY),
    .valid_o   (WVALID),
    .payload_o ({WSTRB, WDATA})
  );

  axi4_lite_valid_hold #(.WIDTH(ADDR_WIDTH)) u_ar_hold (
    .clk_i     (ACLK),
    .rst_ni    (ARESETN),
    .load_i    (load_rd),
    .payload_i (cmd_addr),
    .ready_i   (ARREADY),
    .valid_o   (ARVALID),
    .payload_o (ARADDR)
  );

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    BREADY    = 1'b0;
    RREADY    = 1'b0;
    rsp_valid = 1'b0;
    load_wr   = 1'b0;
    load_rd   = 1'b0;
    cap_b     = 1'b0;
    cap_r     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_write) begin
            load_wr = 1'b1;
            state_d = ST_WR_REQ;
          end else begin
            load_rd = 1'b1;
            state_d = ST_RD_REQ;
          end
        end
      end
      // AW and W retire independently; leave once neither will still be valid next cycle.
      ST_WR_REQ: begin
        if ((!AWVALID || AWREADY) && (!WVALID || WREADY)) begin
          state_d = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        BREADY = 1'b1;
        if (BVALID) begin
          cap_b   = 1'b1;
          state_d = ST_RSP;
        end
      end
      ST_RD_REQ: begin
        if (ARVALID && ARREADY) begin
          state_d = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        RREADY = 1'b1;
        if (RVALID) begin
          cap_r   = 1'b1;
          state_d = ST_RSP;
        end
      end
      ST_RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cap_resp = cap_b ? BRESP : RRESP;

  always_comb begin
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    rsp_write_d = rsp_write_q;
    err_count_d = err_count_q;
    if (cap_b) begin
      rsp_rdata_d = '0;
      rsp_resp_d  = BRESP;
      rsp_write_d = 1'b1;
    end else if (cap_r) begin
      rsp_rdata_d = RDATA;
      rsp_resp_d  = RRESP;
      rsp_write_d = 1'b0;
    end
    // Saturate rather than wrap so a flood of errors never reads back as few.
    if ((cap_b || cap_r) && resp_is_err(cap_resp) && (err_count_q != '1)) begin
      err_count_d = err_count_q + ERR_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rsp_rdata_q <= '0;
      rsp_resp_q  <= RESP_OKAY;
      rsp_write_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      rsp_write_q <= rsp_write_d;
      err_count_q <= err_count_d;
    end
  end

  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign rsp_write = rsp_write_q;
  assign err_count = err_count_q;

endmodule
